// File: rtl/ddr_gray_counter.sv
// Dual-edge Gray-code counter: rising and falling register banks muxed by clk level.
// Outputs change in the half-period after an active edge; no input-to-output combinational path.
`timescale 1ns/1ps
module ddr_gray_counter #(
  parameter int          WIDTH     = 4,
  parameter int          EDGE_MODE = 0,
  parameter int unsigned RST_VAL   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] RST_BIN = RST_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAXV    = {WIDTH{1'b1}};

  logic [WIDTH-1:0] rise_bin_q, rise_bin_d;
  logic             rise_wrap_q, rise_wrap_d;
  logic [WIDTH-1:0] fall_bin_q, fall_bin_d;
  logic             fall_wrap_q, fall_wrap_d;
  logic             mux_sel;

  // Returns {wrap_next, bin_next} for a given currently-displayed count.
  function automatic logic [WIDTH:0] step_count(
    input logic [WIDTH-1:0] cur,
    input logic             ld,
    input logic             inc,
    input logic [WIDTH-1:0] ld_val
  );
    logic [WIDTH:0] res;
    res = {1'b0, cur};
    if (ld)
      res = {1'b0, ld_val};
    else if (inc)
      res = {(cur == MAXV), cur + ONE};
    return res;
  endfunction

  // Just before a posedge the display shows the falling bank (and vice versa),
  // so each bank steps from the other bank's value rather than the mux output.
  always_comb begin
    {rise_wrap_d, rise_bin_d} = {fall_wrap_q, fall_bin_q};
    {fall_wrap_d, fall_bin_d} = {rise_wrap_q, rise_bin_q};
    if (EDGE_MODE != 2)
      {rise_wrap_d, rise_bin_d} = step_count(fall_bin_q, load, en, load_val);
    if (EDGE_MODE != 1)
      {fall_wrap_d, fall_bin_d} = step_count(rise_bin_q, load, en, load_val);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_bin_q  <= RST_BIN;
      rise_wrap_q <= 1'b0;
    end else begin
      rise_bin_q  <= rise_bin_d;
      rise_wrap_q <= rise_wrap_d;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      fall_bin_q  <= RST_BIN;
      fall_wrap_q <= 1'b0;
    end else begin
      fall_bin_q  <= fall_bin_d;
      fall_wrap_q <= fall_wrap_d;
    end
  end

  // In silicon this select is clk through two buffers so it settles after the bank flops.
  assign mux_sel  = clk;
  assign bin_out  = mux_sel ? rise_bin_q  : fall_bin_q;
  assign wrap     = mux_sel ? rise_wrap_q : fall_wrap_q;
  assign gray_out = bin_out ^ (bin_out >> 1);

endmodule

// File: doc/ddr_gray_counter.md
Name: ddr_gray_counter

Overview:
- Parametrised dual-edge Gray-code counter for the gray tree. It is the next generation of the single-bit dual-edge flop.
- Holds a WIDTH-bit count that can advance on rising edges, falling edges or both edges of one clock. Output is Gray code, with a binary copy.
- Supports synchronous load, count enable and a wrap flag.
- Used as a DDR timestamp/phase counter feeding downstream Gray-to-binary tree logic and clock-domain crossings.

Parameters:
- WIDTH, 4, count width in bits (minimum 2).
- EDGE_MODE, 0, active edges: 0 = both edges, 1 = rising only, 2 = falling only.
- RST_VAL, 0, binary count value loaded on reset (must be < 2^WIDTH).

Ports:
- clk  input  1  counter clock. Also the select for the output edge mux.
- rst  input  1  asynchronous reset, active-high.
- en  input  1  count enable, sampled at every active edge.
- load  input  1  synchronous load, sampled at every active edge. Has priority over en.
- load_val  input  WIDTH  binary value to load.
- gray_out  output  WIDTH  current count, Gray coded.
- bin_out  output  WIDTH  current count, binary.
- wrap  output  1  high for the half-period after the count steps from 2^WIDTH-1 to 0.

Behaviour:
- Structure:
  - Rising bank: WIDTH+1 flops updated on posedge clk.
  - Falling bank: WIDTH+1 flops updated on negedge clk.
  - Each bank holds the binary count plus wrap.
  - Output mux: clk high selects the rising bank; clk low selects the falling bank.
  - The mux select is clk through two buffer cells, so the select settles after the bank flops update. This prevents a glitch on gray_out at each edge.
- Next-state function: both banks compute next from the currently muxed bin_out.
  - If load: next = load_val, wrap_next = 0.
  - Else if en: next = bin_out + 1 mod 2^WIDTH, wrap_next = (bin_out == 2^WIDTH-1).
  - Else: next = bin_out, wrap_next = 0.
- EDGE_MODE=0: both banks active. The count can change every half-period, i.e. two increments per clk cycle.
- EDGE_MODE=1:
  - Falling bank copies the rising bank at each negedge, so the output is stable for a full cycle.
  - wrap copies too, so it is high for one full cycle.
- EDGE_MODE=2: mirror of mode 1. Rising bank copies the falling bank.
- gray_out = bin_out ^ (bin_out >> 1), decoded combinationally from the muxed binary. Successive counts differ in exactly one bit.
- Latency: a change on en/load/load_val set up before an active edge is visible on outputs in the half-period that follows that edge.
- Reset:
  - rst high asynchronously forces both banks to RST_VAL and wrap to 0.
  - Outputs are gray(RST_VAL), bin_out = RST_VAL, wrap = 0 regardless of clk level.
  - On rst release, the first active edge after release counts normally. No dead edge.
  - Reset asserted mid-count: outputs return to the reset values immediately, with no partial update.
- Boundaries:
  - Count 2^WIDTH-1 with en=1 steps to 0 and asserts wrap. Gray value steps from 1000.. to 0000.. with a single bit change.
  - load and en both high: load wins, no increment, wrap = 0.
  - load_val = 2^WIDTH-1 with en on the following edge: count wraps to 0 with wrap = 1.
  - en = 0: count holds, wrap drops to 0 at the next active edge.
- No combinational path from inputs to outputs. The only non-flop path is the clk-controlled mux.

Test Plan:
- WIDTH=4, EDGE_MODE=0, RST_VAL=0; release rst, en=1 for 4 clk cycles -> bin_out 1..8 (one step per edge); gray_out 0001,0011,0010,0110,0111,0101,0100,1100; exactly one gray bit changes per step.
- EDGE_MODE=0; load=1, load_val=14 at a posedge, then en=1 with load=0 -> bin_out 14, 15, 0, 1; wrap high only during the half-period with bin_out=0; gray 1001,1000,0000,0001.
- EDGE_MODE=1; en=1 for 3 cycles -> bin_out increments only at posedges (1,2,3) and is stable across the negedges; the EDGE_MODE=2 mirror changes only at negedges.
- load=1 and en=1 at the same edge with load_val=5 -> bin_out=5, no increment, wrap=0. Then en=0 -> count holds at 5 for 4 edges.
- Assert rst asynchronously mid-half-period while count=9 with clk high, then with clk low, RST_VAL=3 -> bin_out=3, gray_out=0010, wrap=0 immediately in both cases. The first edge after release gives 4.
- Glitch check: across 64 edges in EDGE_MODE=0, sample gray_out 0.1 ns after each edge -> never an intermediate value; Hamming distance to the previous value is ≤ 1.
